clock_run_controller: RTL and testbench

- Controls the processor's execution rate on the FPGA board.
- Generates a one-cycle `cpu_tick` clock-enable from the 50 MHz `clock`, in one of three ways:
  - at a programmable divided rate (RUN);
  - one tick per debounced push-button press (STEP);
  - not at all (HALT, BREAK).
- Replaces free-running derived clocks: the processor runs on `clock` and gates state updates with `cpu_tick`.
- Also holds a programmable divisor, accepts a halt request from the processor, and counts issued ticks.

---
 rtl/clock_ctrl_pkg.sv | 17 +
 rtl/clock_run_controller_debouncer.sv | 51 +++++
 rtl/clock_run_controller.sv | 141 ++++++++++++++
 tb/tb_clock_run_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared constants and state encoding for the clock run controller.
package clock_ctrl_pkg;

   localparam int unsigned CLK_DIV_WIDTH = 28;
   localparam int unsigned CLK_DEB_WIDTH = 20;

   localparam logic [CLK_DIV_WIDTH-1:0] CLK_DEFAULT_DIVISOR = 28'd50000000;
   localparam logic [CLK_DEB_WIDTH-1:0] CLK_DEBOUNCE_CYCLES = 20'd500000;

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_BREAK = 2'b11
   } run_state_e;

endpackage

// File: rtl/clock_run_controller_debouncer.sv
// Two-flop synchronizer plus level debouncer for a bouncy board input,
// with a registered one-cycle pulse on each debounced rising edge.
module button_debouncer
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned               DEB_WIDTH       = CLK_DEB_WIDTH,
   parameter logic [DEB_WIDTH-1:0]      DEBOUNCE_CYCLES = DEB_WIDTH'(CLK_DEBOUNCE_CYCLES)
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam logic [DEB_WIDTH-1:0] LP_CNT_LAST = DEBOUNCE_CYCLES - DEB_WIDTH'(1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_level;
   logic                 r_rise;
   logic [DEB_WIDTH-1:0] r_cnt;

   // Any sample agreeing with the current level restarts the stability count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == LP_CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_rise  <= r_sync2;
         end else begin
            r_cnt <= r_cnt + DEB_WIDTH'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/clock_run_controller.sv
// Processor execution-rate controller: issues a one-cycle cpu_tick enable
// at a programmable rate (RUN), once per button press (STEP), or not at all.
module clock_run_controller
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned               DIV_WIDTH       = CLK_DIV_WIDTH,
   parameter logic [DIV_WIDTH-1:0]      DEFAULT_DIVISOR = DIV_WIDTH'(CLK_DEFAULT_DIVISOR),
   parameter int unsigned               DEB_WIDTH       = CLK_DEB_WIDTH,
   parameter logic [DEB_WIDTH-1:0]      DEBOUNCE_CYCLES = DEB_WIDTH'(CLK_DEBOUNCE_CYCLES)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run_sw,
   input  logic                 step_btn,
   input  logic                 halt_req,
   input  logic                 divisor_load,
   input  logic [DIV_WIDTH-1:0] divisor_in,
   output logic                 cpu_tick,
   output logic [1:0]           run_state,
   output logic [31:0]          tick_count
);

   run_state_e           r_state;
   logic                 r_tick;
   logic [DIV_WIDTH-1:0] r_rate_cnt;
   logic [DIV_WIDTH-1:0] r_divisor;
   logic [31:0]          r_tick_count;

   run_state_e           w_state_nxt;
   logic                 w_tick_nxt;
   logic [DIV_WIDTH-1:0] w_rate_nxt;
   logic                 w_rate_wrap;
   logic [DIV_WIDTH-1:0] w_div_clamped;

   logic                 w_run_db;
   logic                 w_run_rise_unused;
   logic                 w_step_level_unused;
   logic                 w_step_pulse;

   button_debouncer #(
      .DEB_WIDTH       (DEB_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_run_deb (
      .clock   (clock),
      .reset   (reset),
      .i_raw   (run_sw),
      .o_level (w_run_db),
      .o_rise  (w_run_rise_unused)
   );

   button_debouncer #(
      .DEB_WIDTH       (DEB_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_deb (
      .clock   (clock),
      .reset   (reset),
      .i_raw   (step_btn),
      .o_level (w_step_level_unused),
      .o_rise  (w_step_pulse)
   );

   // Zero divisor would make divisor-1 wrap, so it is clamped to 1.
   assign w_div_clamped = (divisor_in == '0) ? DIV_WIDTH'(1) : divisor_in;
   assign w_rate_wrap   = (r_rate_cnt == (r_divisor - DIV_WIDTH'(1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_HALT;
         r_tick     <= 1'b0;
         r_rate_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick     <= w_tick_nxt;
         r_rate_cnt <= w_rate_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = 1'b0;
      w_rate_nxt  = '0;
      case (r_state)
         ST_HALT: begin
            if (w_run_db) begin
               w_state_nxt = ST_RUN;
            end else if (w_step_pulse) begin
               w_state_nxt = ST_STEP;
               w_tick_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               w_state_nxt = ST_BREAK;
            end else if (!w_run_db) begin
               w_state_nxt = ST_HALT;
            end else if (w_rate_wrap) begin
               w_tick_nxt = 1'b1;
            end else begin
               w_rate_nxt = r_rate_cnt + DIV_WIDTH'(1);
            end
         end
         ST_STEP: begin
            w_state_nxt = ST_HALT;
         end
         ST_BREAK: begin
            if (!w_run_db) begin
               w_state_nxt = ST_HALT;
            end
         end
         default: begin
            w_state_nxt = ST_HALT;
         end
      endcase
      // A divisor load restarts the rate period and drops any pending rate tick.
      if (divisor_load) begin
         w_rate_nxt = '0;
         if (r_state == ST_RUN) begin
            w_tick_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_divisor    <= DEFAULT_DIVISOR;
         r_tick_count <= '0;
      end else begin
         if (divisor_load) begin
            r_divisor <= w_div_clamped;
         end
         if (r_tick) begin
            r_tick_count <= r_tick_count + 32'd1;
         end
      end
   end

   assign cpu_tick   = r_tick;
   assign run_state  = r_state;
   assign tick_count = r_tick_count;

endmodule

// File: tb/tb_clock_run_controller.sv
// Scoreboard bench for clock_run_controller with a short debounce window.
module tb_clock_run_controller;
   import clock_ctrl_pkg::*;

   localparam int unsigned DEB = 4;
   // raw input -> 2 sync flops -> DEB stable samples -> FSM register
   localparam int          LAT = 2 + int'(DEB) + 1;

   logic        clock = 1'b0;
   logic        reset;
   logic        run_sw;
   logic        step_btn;
   logic        halt_req;
   logic        divisor_load;
   logic [27:0] divisor_in;
   logic        cpu_tick;
   logic [1:0]  run_state;
   logic [31:0] tick_count;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;

   typedef struct {
      int         cyc;
      logic [1:0] st;
   } tick_exp_t;

   tick_exp_t sb[$];

   clock_run_controller #(
      .DEBOUNCE_CYCLES (20'(DEB))
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .run_sw       (run_sw),
      .step_btn     (step_btn),
      .halt_req     (halt_req),
      .divisor_load (divisor_load),
      .divisor_in   (divisor_in),
      .cpu_tick     (cpu_tick),
      .run_state    (run_state),
      .tick_count   (tick_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   task automatic push_tick(input int c, input logic [1:0] st);
      tick_exp_t e;
      e.cyc = c;
      e.st  = st;
      sb.push_back(e);
      exp_cnt++;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   task automatic load_div(input logic [27:0] v);
      divisor_in   = v;
      divisor_load = 1'b1;
      @(negedge clock);
      divisor_load = 1'b0;
   endtask

   // Raise run_sw, expect n ticks every d cycles, break with halt_req, then drop run_sw.
   task automatic run_burst(input logic [27:0] load_val, input int d, input int n);
      int c;
      int c0;
      load_div(load_val);
      c      = cyc;
      run_sw = 1'b1;
      c0     = c + LAT;
      for (int k = 1; k <= n; k++) push_tick(c0 + d * k, 2'(ST_RUN));
      wait_cyc(c0);
      chk("burst_run", 32'(run_state), 32'(ST_RUN));
      wait_cyc(c0 + d * n);
      halt_req = 1'b1;
      wait_cyc(c0 + d * n + 1);
      halt_req = 1'b0;
      chk("burst_break", 32'(run_state), 32'(ST_BREAK));
      chk("burst_count", tick_count, 32'(exp_cnt));
      c      = cyc;
      run_sw = 1'b0;
      wait_cyc(c + LAT - 1);
      chk("burst_still_break", 32'(run_state), 32'(ST_BREAK));
      wait_cyc(c + LAT);
      chk("burst_halt", 32'(run_state), 32'(ST_HALT));
   endtask

   // Every cycle: a tick must appear exactly where the scoreboard predicts it.
   always @(negedge clock) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         chk("tick", 32'(cpu_tick), 32'd1);
         chk("tick_state", 32'(run_state), 32'(sb[0].st));
         sb.delete(0);
      end else begin
         chk("tick_idle", 32'(cpu_tick), 32'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c;
      int c0;
      reset        = 1'b1;
      run_sw       = 1'b0;
      step_btn     = 1'b0;
      halt_req     = 1'b0;
      divisor_load = 1'b0;
      divisor_in   = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst_state", 32'(run_state), 32'(ST_HALT));
      chk("rst_tick", 32'(cpu_tick), 32'd0);
      chk("rst_count", tick_count, 32'd0);

      // divisor 0 is clamped to 1: tick every cycle from the 2nd RUN cycle
      run_burst(28'd0, 1, 3);
      // divisor 4: ticks in RUN cycles 5, 9, 13
      run_burst(28'd4, 4, 3);

      // step button bounces 1-0-1 then holds: exactly one STEP tick
      step_btn = 1'b1;
      @(negedge clock);
      step_btn = 1'b0;
      @(negedge clock);
      step_btn = 1'b1;
      c = cyc;
      push_tick(c + LAT, 2'(ST_STEP));
      wait_cyc(c + LAT + 1);
      chk("step_halt", 32'(run_state), 32'(ST_HALT));
      chk("step_count", tick_count, 32'(exp_cnt));
      wait_cyc(c + 10);
      step_btn = 1'b0;
      wait_cyc(cyc + LAT + 2);

      // divisor 2: halt_req on the wrap cycle beats the tick
      load_div(28'd2);
      c      = cyc;
      run_sw = 1'b1;
      c0     = c + LAT;
      wait_cyc(c0);
      chk("brk_run", 32'(run_state), 32'(ST_RUN));
      wait_cyc(c0 + 1);
      halt_req = 1'b1;
      wait_cyc(c0 + 2);
      halt_req = 1'b0;
      chk("brk_enter", 32'(run_state), 32'(ST_BREAK));
      step_btn = 1'b1;
      c = cyc;
      wait_cyc(c + 10);
      chk("brk_step_ignored", 32'(run_state), 32'(ST_BREAK));
      step_btn = 1'b0;
      halt_req = 1'b1;
      @(negedge clock);
      halt_req = 1'b0;
      wait_cyc(cyc + LAT + 2);
      chk("brk_hold", 32'(run_state), 32'(ST_BREAK));
      chk("brk_count", tick_count, 32'(exp_cnt));
      c      = cyc;
      run_sw = 1'b0;
      wait_cyc(c + LAT - 1);
      chk("brk_still", 32'(run_state), 32'(ST_BREAK));
      wait_cyc(c + LAT);
      chk("brk_exit", 32'(run_state), 32'(ST_HALT));

      // divisor 3, reload 5 mid-count, then reset while running
      load_div(28'd3);
      c      = cyc;
      run_sw = 1'b1;
      c0     = c + LAT;
      push_tick(c0 + 3, 2'(ST_RUN));
      push_tick(c0 + 6, 2'(ST_RUN));
      wait_cyc(c0 + 7);
      divisor_in   = 28'd5;
      divisor_load = 1'b1;
      push_tick(c0 + 13, 2'(ST_RUN));
      push_tick(c0 + 18, 2'(ST_RUN));
      wait_cyc(c0 + 8);
      divisor_load = 1'b0;
      chk("load_state", 32'(run_state), 32'(ST_RUN));
      wait_cyc(c0 + 19);
      chk("pre_rst_count", tick_count, 32'(exp_cnt));
      reset  = 1'b1;
      run_sw = 1'b0;
      wait_cyc(c0 + 20);
      reset = 1'b0;
      chk("mid_rst_state", 32'(run_state), 32'(ST_HALT));
      chk("mid_rst_tick", 32'(cpu_tick), 32'd0);
      chk("mid_rst_count", tick_count, 32'd0);
      wait_cyc(cyc + 12);
      chk("post_rst_state", 32'(run_state), 32'(ST_HALT));
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
